block_rom_arbiter: RTL and testbench

BLOCK_ROM_ARBITER -- requirements
Module: block_rom_arbiter

---
 rtl/block_rom_arbiter.sv | 117 +++++++++++
 tb/tb_block_rom_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/block_rom_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous ROM.
// Alternating priority on contention, fixed two-cycle read latency per grant.

module block_rom_arbiter_ret #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= capture;
            if (capture)
                data <= rom_q;
        end
    end

endmodule

module block_rom_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic                  a_ack,
    output logic                  a_valid,
    output logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_ack,
    output logic                  b_valid,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q
);

    localparam int NUM_REQ = 2;
    localparam int STAGES  = 2;

    logic                                  last_b;
    logic [NUM_REQ-1:0]                    ack;
    logic                                  xfer;
    logic                                  win_b;
    logic [STAGES:1]                       vld_pipe;
    logic [STAGES:1]                       id_pipe;
    logic [NUM_REQ-1:0]                    capture;
    logic [NUM_REQ-1:0]                    valid_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    data_v;

    // A wins when alone or when B took the previous grant.
    always_comb begin
        ack = '0;
        if (!reset) begin
            if (a_req && (!b_req || last_b))
                ack[0] = 1'b1;
            else if (b_req)
                ack[1] = 1'b1;
        end
    end

    assign a_ack = ack[0];
    assign b_ack = ack[1];
    assign xfer  = |ack;
    assign win_b = ack[1];

    // Stage 1 covers the ROM sampling cycle, stage 2 the cycle rom_q is valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b   <= 1'b1;
            rom_addr <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
            id_pipe  <= {id_pipe[STAGES-1:1], win_b};
            if (xfer) begin
                last_b   <= win_b;
                rom_addr <= win_b ? b_addr : a_addr;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ret
            assign capture[gi] = vld_pipe[STAGES] && (id_pipe[STAGES] == (gi == 1));

            block_rom_arbiter_ret #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_ret (
                .clk    (clk),
                .reset  (reset),
                .capture(capture[gi]),
                .rom_q  (rom_q),
                .valid  (valid_v[gi]),
                .data   (data_v[gi])
            );
        end
    endgenerate

    assign a_valid = valid_v[0];
    assign a_data  = data_v[0];
    assign b_valid = valid_v[1];
    assign b_data  = data_v[1];

endmodule

// File: tb/tb_block_rom_arbiter.sv
// Directed bench for block_rom_arbiter with a behavioural synchronous ROM.

module tb_block_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, b_req;
    logic [4:0] a_addr, b_addr;
    logic       a_ack, b_ack, a_valid, b_valid;
    logic [9:0] a_data, b_data;
    logic [4:0] rom_addr;
    logic [9:0] rom_q;
    logic [9:0] rom [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    block_rom_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_valid(a_valid), .a_data(a_data),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_valid(b_valid), .b_data(b_data),
        .rom_addr(rom_addr), .rom_q(rom_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant exclusivity and reset gating, checked every cycle.
    always @(negedge clk) begin
        vectors++;
        assert (!(a_ack && b_ack) && !(reset && (a_ack || b_ack))) else begin
            miscompares++;
            $error("FAIL ack_excl: observed a_ack=%0b b_ack=%0b reset=%0b expected exclusive, none in reset",
                   a_ack, b_ack, reset);
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 10'(i * 37 + 17);
        rom[5] = 10'h2A3;

        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_addr = 5'd0; b_addr = 5'd0;
        tick();
        tick();
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_b_data", b_data, 0);
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0;

        // A-only read of address 5
        a_req = 1'b1; a_addr = 5'd5;
        #1;
        chk("aonly_a_ack", a_ack, 1);
        chk("aonly_b_ack", b_ack, 0);
        tick();
        a_req = 1'b0;
        chk("aonly_rom_addr", rom_addr, 5);
        chk("aonly_valid_k", a_valid, 0);
        tick();
        chk("aonly_valid_k1", a_valid, 0);
        tick();
        chk("aonly_valid_k2", a_valid, 1);
        chk("aonly_data", a_data, 10'h2A3);
        chk("aonly_b_valid", b_valid, 0);
        tick();
        chk("aonly_valid_off", a_valid, 0);
        chk("aonly_data_hold", a_data, 10'h2A3);

        // fresh reset so the contention below is the first after reset
        reset = 1'b1;
        #6;
        reset = 1'b0;
        tick();

        a_addr = 5'd1; b_addr = 5'd2;
        for (int j = 0; j < 6; j++) begin
            a_req = (j < 4); b_req = (j < 4);
            #1;
            if (j < 4) begin
                chk("cont_a_ack", a_ack, (j % 2 == 0));
                chk("cont_b_ack", b_ack, (j % 2 == 1));
            end
            tick();
            if (j < 4) chk("cont_rom_addr", rom_addr, (j % 2 == 0) ? 1 : 2);
            if (j >= 2) begin
                chk("cont_a_valid", a_valid, ((j - 2) % 2 == 0));
                chk("cont_b_valid", b_valid, ((j - 2) % 2 == 1));
                if ((j - 2) % 2 == 0) chk("cont_a_data", a_data, rom[1]);
                else                  chk("cont_b_data", b_data, rom[2]);
            end
        end
        a_req = 1'b0; b_req = 1'b0;

        // A streams 0..31 then 0 again
        for (int i = 0; i < 36; i++) begin
            a_req = (i < 33);
            a_addr = 5'(i % 32);
            #1;
            if (i < 33) chk("strm_a_ack", a_ack, 1);
            tick();
            if (i < 33) chk("strm_rom_addr", rom_addr, i % 32);
            if (i >= 2 && i <= 34) begin
                chk("strm_a_valid", a_valid, 1);
                chk("strm_a_data", a_data, rom[(i - 2) % 32]);
            end else begin
                chk("strm_a_valid_idle", a_valid, 0);
            end
        end
        a_req = 1'b0;

        // B transfer, then reset before its data returns
        b_req = 1'b1; b_addr = 5'd7;
        #1;
        chk("rmf_b_ack", b_ack, 1);
        tick();
        b_req = 1'b0;
        chk("rmf_rom_addr", rom_addr, 7);
        tick();
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("rmf_a_ack_rst", a_ack, 0);
        chk("rmf_b_ack_rst", b_ack, 0);
        chk("rmf_rom_addr_rst", rom_addr, 0);
        chk("rmf_b_data_rst", b_data, 0);
        #5;
        reset = 1'b0;
        a_addr = 5'd3; b_addr = 5'd4;
        #1;
        chk("rmf_first_a_ack", a_ack, 1);
        chk("rmf_first_b_ack", b_ack, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        chk("rmf_b_valid_k2", b_valid, 0);
        chk("rmf_rom_addr_new", rom_addr, 3);
        tick();
        chk("rmf_b_valid_k3", b_valid, 0);
        tick();
        chk("rmf_a_valid", a_valid, 1);
        chk("rmf_a_data", a_data, rom[3]);
        chk("rmf_b_valid_k4", b_valid, 0);
        chk("rmf_b_data", b_data, 0);
        tick();

        // A pulses for one cycle while B wins and holds the grant
        a_req = 1'b1; b_req = 1'b1; a_addr = 5'd9; b_addr = 5'd10;
        #1;
        chk("drop_b_ack1", b_ack, 1);
        chk("drop_a_ack1", a_ack, 0);
        tick();
        chk("drop_rom_addr1", rom_addr, 10);
        a_req = 1'b0; b_addr = 5'd11;
        #1;
        chk("drop_b_ack2", b_ack, 1);
        tick();
        b_req = 1'b0;
        chk("drop_rom_addr2", rom_addr, 11);
        chk("drop_a_valid0", a_valid, 0);
        tick();
        chk("drop_b_valid1", b_valid, 1);
        chk("drop_b_data1", b_data, rom[10]);
        chk("drop_a_valid1", a_valid, 0);
        tick();
        chk("drop_b_valid2", b_valid, 1);
        chk("drop_b_data2", b_data, rom[11]);
        chk("drop_a_valid2", a_valid, 0);
        tick();
        chk("idle_b_valid", b_valid, 0);
        chk("idle_rom_addr", rom_addr, 11);
        chk("idle_a_data", a_data, rom[3]);
        chk("idle_b_data", b_data, rom[11]);
        a_req = 1'b1; b_req = 1'b1;
        #1;
        chk("after_drop_a_ack", a_ack, 1);
        chk("after_drop_b_ack", b_ack, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
